// File: rtl/sync_down_counter.sv
// Synchronous down counter: MAX..0 then wraps, with clamped load, TC cascade and WRAP pulse.
// Define DOWN_COUNTER_ONESHOT_EN to add OS/DONE one-shot stop at zero.
module sync_down_counter #(
    parameter int WIDTH = 4,
    parameter int MAX   = 15
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic             E,
    input  logic             LD,
    input  logic [WIDTH-1:0] D,
`ifdef DOWN_COUNTER_ONESHOT_EN
    input  logic             OS,
    output logic             DONE,
`endif
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Q_n,
    output logic             TC,
    output logic             WRAP
);

    localparam logic [0:0] RUN  = 1'b0;
    localparam logic [0:0] HOLD = 1'b1;

    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MAX);

    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] q_nxt;
    logic [WIDTH-1:0] ld_val;
    logic             wrap_r;
    logic             wrap_nxt;
    logic [0:0]       state;
    logic [0:0]       state_nxt;
    logic             at_zero;
    logic             run;
    logic             os_stop;

`ifdef DOWN_COUNTER_ONESHOT_EN
    assign os_stop = OS;
    assign DONE    = (state == HOLD);
`else
    assign os_stop = 1'b0;
`endif

    assign at_zero = (q_r == '0);
    assign run     = (state == RUN);
    // Clamp rather than truncate so Q can never exceed MAX.
    assign ld_val  = (D > MAX_Q) ? MAX_Q : D;

    always_comb begin
        q_nxt     = q_r;
        wrap_nxt  = 1'b0;
        state_nxt = state;
        if (LD) begin
            q_nxt     = ld_val;
            state_nxt = RUN;
        end else if (E && run) begin
            if (!at_zero) begin
                q_nxt = q_r - 1'b1;
            end else if (os_stop) begin
                state_nxt = HOLD;
            end else begin
                q_nxt    = MAX_Q;
                wrap_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            q_r    <= '0;
            wrap_r <= 1'b0;
            state  <= RUN;
        end else begin
            q_r    <= q_nxt;
            wrap_r <= wrap_nxt;
            state  <= state_nxt;
        end
    end

    assign Q    = q_r;
    assign Q_n  = ~q_r;
    assign WRAP = wrap_r;
    assign TC   = E & at_zero & run;

endmodule

// File: tb/tb_sync_down_counter.sv
// Self-checking bench for sync_down_counter: vector table, clear, clamp, cascade, MAX=0.
// Exercises the one-shot path too when DOWN_COUNTER_ONESHOT_EN is defined.
module tb_sync_down_counter;

    typedef struct {
        logic       ld;
        logic       e;
        logic [3:0] d;
        logic       tc;
        logic [3:0] q;
        logic       wrap;
    } vec_t;

    typedef struct {
        logic [7:0] q;
        logic       wrap;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       clr_a, e_a, ld_a;
    logic [3:0] d_a, q_a, qn_a;
    logic       tc_a, wrap_a;

    logic       clr_o;
    logic       e_b, ld_b;
    logic [3:0] d_b, q_b, qn_b;
    logic       tc_b, wrap_b;

    logic       e_z;
    logic       ld_z;
    logic [1:0] d_z, q_z, qn_z;
    logic       tc_z, wrap_z;

    logic       e_c, ld_c;
    logic [3:0] d_c;
    logic [3:0] q_lo, qn_lo, q_hi, qn_hi;
    logic       tc_lo, wrap_lo, tc_hi, wrap_hi;

`ifdef DOWN_COUNTER_ONESHOT_EN
    logic os_a, done_a, os_off;
    logic done_b, done_z, done_lo, done_hi;
`endif

    sync_down_counter #(.WIDTH(4), .MAX(15)) u_a (
        .CLK(clk), .CLR(clr_a), .E(e_a), .LD(ld_a), .D(d_a),
`ifdef DOWN_COUNTER_ONESHOT_EN
        .OS(os_a), .DONE(done_a),
`endif
        .Q(q_a), .Q_n(qn_a), .TC(tc_a), .WRAP(wrap_a)
    );

    sync_down_counter #(.WIDTH(4), .MAX(10)) u_b (
        .CLK(clk), .CLR(clr_o), .E(e_b), .LD(ld_b), .D(d_b),
`ifdef DOWN_COUNTER_ONESHOT_EN
        .OS(os_off), .DONE(done_b),
`endif
        .Q(q_b), .Q_n(qn_b), .TC(tc_b), .WRAP(wrap_b)
    );

    sync_down_counter #(.WIDTH(2), .MAX(0)) u_z (
        .CLK(clk), .CLR(clr_o), .E(e_z), .LD(ld_z), .D(d_z),
`ifdef DOWN_COUNTER_ONESHOT_EN
        .OS(os_off), .DONE(done_z),
`endif
        .Q(q_z), .Q_n(qn_z), .TC(tc_z), .WRAP(wrap_z)
    );

    sync_down_counter #(.WIDTH(4), .MAX(15)) u_lo (
        .CLK(clk), .CLR(clr_o), .E(e_c), .LD(ld_c), .D(d_c),
`ifdef DOWN_COUNTER_ONESHOT_EN
        .OS(os_off), .DONE(done_lo),
`endif
        .Q(q_lo), .Q_n(qn_lo), .TC(tc_lo), .WRAP(wrap_lo)
    );

    sync_down_counter #(.WIDTH(4), .MAX(15)) u_hi (
        .CLK(clk), .CLR(clr_o), .E(tc_lo), .LD(ld_c), .D(d_c),
`ifdef DOWN_COUNTER_ONESHOT_EN
        .OS(os_off), .DONE(done_hi),
`endif
        .Q(q_hi), .Q_n(qn_hi), .TC(tc_hi), .WRAP(wrap_hi)
    );

    int   n_vec = 0;
    int   n_bad = 0;
    exp_t sb[$];
    vec_t vecs[27];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic ld, input logic e,
                                input logic [3:0] d, input logic tc,
                                input logic [3:0] q, input logic w);
        vec_t v;
        v.ld = ld; v.e = e; v.d = d;
        v.tc = tc; v.q = q; v.wrap = w;
        return v;
    endfunction

    task automatic step_a(input vec_t v, input string nm);
        exp_t x;
        @(negedge clk);
        ld_a = v.ld; e_a = v.e; d_a = v.d;
        #1 chk({nm, ".tc"}, {31'd0, tc_a}, {31'd0, v.tc});
        sb.push_back('{q: {4'd0, v.q}, wrap: v.wrap});
        @(posedge clk);
        #1;
        x = sb.pop_front();
        chk({nm, ".q"}, {28'd0, q_a}, {24'd0, x.q});
        chk({nm, ".q_n"}, {28'd0, qn_a}, {28'd0, ~x.q[3:0]});
        chk({nm, ".wrap"}, {31'd0, wrap_a}, {31'd0, x.wrap});
    endtask

    task automatic step_b(input logic ld, input logic e,
                          input logic [3:0] d, input logic [3:0] q);
        @(negedge clk);
        ld_b = ld; e_b = e; d_b = d;
        sb.push_back('{q: {4'd0, q}, wrap: 1'b0});
        @(posedge clk);
        #1;
        begin
            exp_t x;
            x = sb.pop_front();
            chk("clamp.q", {28'd0, q_b}, {24'd0, x.q});
            chk("clamp.wrap", {31'd0, wrap_b}, {31'd0, x.wrap});
        end
    endtask

    initial begin
        int n;
        logic [7:0] v;
        exp_t x;

        n = 0;
        for (int i = 0; i < 17; i++) begin
            if (i == 0 || i == 16)
                vecs[n] = mk(1'b0, 1'b1, 4'd0, 1'b1, 4'd15, 1'b1);
            else
                vecs[n] = mk(1'b0, 1'b1, 4'd0, 1'b0, 4'(15 - i), 1'b0);
            n++;
        end
        vecs[n++] = mk(1'b1, 1'b1, 4'd6, 1'b0, 4'd6, 1'b0);
        for (int i = 0; i < 5; i++)
            vecs[n++] = mk(1'b0, 1'b0, 4'd0, 1'b0, 4'd6, 1'b0);
        vecs[n++] = mk(1'b1, 1'b0, 4'd9, 1'b0, 4'd9, 1'b0);
        vecs[n++] = mk(1'b1, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0);
        vecs[n++] = mk(1'b0, 1'b1, 4'd0, 1'b1, 4'd15, 1'b1);
        vecs[n++] = mk(1'b0, 1'b0, 4'd0, 1'b0, 4'd15, 1'b0);

        clr_a = 1'b1; e_a = 1'b0; ld_a = 1'b0; d_a = '0;
        clr_o = 1'b1; e_b = 1'b0; ld_b = 1'b0; d_b = '0;
        e_z = 1'b0; ld_z = 1'b0; d_z = '0;
        e_c = 1'b0; ld_c = 1'b0; d_c = '0;
`ifdef DOWN_COUNTER_ONESHOT_EN
        os_a = 1'b0; os_off = 1'b0;
`endif

        #2;
        chk("rst.q", {28'd0, q_a}, 32'd0);
        chk("rst.q_n", {28'd0, qn_a}, 32'd15);
        chk("rst.wrap", {31'd0, wrap_a}, 32'd0);
        chk("rst.tc", {31'd0, tc_a}, 32'd0);
`ifdef DOWN_COUNTER_ONESHOT_EN
        chk("rst.done", {31'd0, done_a}, 32'd0);
`endif
        e_a = 1'b1; ld_a = 1'b1; d_a = 4'd7;
        repeat (2) @(posedge clk);
        #1 chk("rst.held", {28'd0, q_a}, 32'd0);
        @(negedge clk);
        e_a = 1'b0; ld_a = 1'b0; d_a = '0;
        clr_a = 1'b0; clr_o = 1'b0;

        for (int i = 0; i < 27; i++)
            step_a(vecs[i], $sformatf("vec%0d", i));

        for (int i = 0; i < 6; i++)
            step_a(mk(1'b0, 1'b1, 4'd0, 1'b0, 4'(14 - i), 1'b0), "pre_clr");
        @(negedge clk);
        clr_a = 1'b1; e_a = 1'b1;
        #1 chk("aclr.q", {28'd0, q_a}, 32'd0);
        repeat (2) @(posedge clk);
        #1 chk("aclr.held", {28'd0, q_a}, 32'd0);
        chk("aclr.wrap", {31'd0, wrap_a}, 32'd0);
        @(negedge clk);
        clr_a = 1'b0; e_a = 1'b0;
        step_a(mk(1'b0, 1'b1, 4'd0, 1'b1, 4'd15, 1'b1), "post_clr");
        @(negedge clk);
        clr_a = 1'b1;
        #1 chk("aclr.wrap_kill", {31'd0, wrap_a}, 32'd0);
        @(negedge clk);
        clr_a = 1'b0; e_a = 1'b0;

        step_b(1'b1, 1'b1, 4'd13, 4'd10);
        step_b(1'b1, 1'b1, 4'd3, 4'd3);
        step_b(1'b1, 1'b0, 4'd15, 4'd10);
        step_b(1'b1, 1'b1, 4'd10, 4'd10);
        step_b(1'b0, 1'b1, 4'd0, 4'd9);
        @(negedge clk);
        ld_b = 1'b0; e_b = 1'b0;

        @(negedge clk);
        e_z = 1'b1;
        #1 chk("max0.tc", {31'd0, tc_z}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("max0.q", {30'd0, q_z}, 32'd0);
            chk("max0.wrap", {31'd0, wrap_z}, 32'd1);
        end
        @(negedge clk);
        e_z = 1'b0;
        @(posedge clk);
        #1 chk("max0.wrap_off", {31'd0, wrap_z}, 32'd0);

        v = 8'h00;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            e_c = 1'b1;
            v = v - 8'd1;
            sb.push_back('{q: v, wrap: 1'b0});
            @(posedge clk);
            #1;
            x = sb.pop_front();
            chk($sformatf("casc%0d", i), {24'd0, q_hi, q_lo}, {24'd0, x.q});
        end
        @(negedge clk);
        e_c = 1'b0;

`ifdef DOWN_COUNTER_ONESHOT_EN
        @(negedge clk);
        os_a = 1'b1;
        step_a(mk(1'b1, 1'b1, 4'd2, 1'b0, 4'd2, 1'b0), "os.ld");
        step_a(mk(1'b0, 1'b1, 4'd0, 1'b0, 4'd1, 1'b0), "os.e1");
        chk("os.done1", {31'd0, done_a}, 32'd0);
        step_a(mk(1'b0, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0), "os.e2");
        chk("os.done2", {31'd0, done_a}, 32'd0);
        step_a(mk(1'b0, 1'b1, 4'd0, 1'b1, 4'd0, 1'b0), "os.e3");
        chk("os.done3", {31'd0, done_a}, 32'd1);
        step_a(mk(1'b0, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0), "os.e4");
        chk("os.done4", {31'd0, done_a}, 32'd1);
        step_a(mk(1'b1, 1'b1, 4'd5, 1'b0, 4'd5, 1'b0), "os.reld");
        chk("os.done5", {31'd0, done_a}, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/sync_down_counter.md
Name: sync_down_counter

Overview:
- Synchronous, parameterised down counter. It is the counting-direction counterpart to the team's ripple up counter.
- Counts MAX, MAX-1, …, 0, then wraps back to MAX.
- Supports parallel load, a cascade terminal-count output and a registered wrap pulse.
- Used as a reload/timeout counter alongside the up counters in the lab designs. Cascades to wider counts via TC → E of the next stage.

Parameters:
- WIDTH, 4: counter width in bits (2..16).
- MAX, 15: reload value on wrap. It is also the load clamp limit and must be ≤ 2^WIDTH-1.

Ports:
- CLK  input  1  rising-edge clock.
- CLR  input  1  asynchronous, active-high reset.
- E  input  1  count enable. Decrement on a rising CLK edge when high.
- LD  input  1  synchronous parallel load, with priority over E.
- D  input  WIDTH  load value.
- Q  output  WIDTH  current count.
- Q_n  output  WIDTH  bitwise complement of Q.
- TC  output  1  terminal count, combinational: E & (Q == 0).
- WRAP  output  1  registered one-cycle pulse following a wrap.

Behaviour:
- Reset: CLR high forces Q = 0, WRAP = 0 and the state machine to RUN immediately, with no clock needed. While CLR is held, edges are ignored. After release, the first edge is processed normally.
- Edge priority, per rising CLK edge: CLR > LD > E > hold.
- LD = 1: Q ← min(D, MAX). WRAP ← 0. E is ignored that cycle. State ← RUN.
- LD = 0, E = 1, Q > 0: Q ← Q-1. WRAP ← 0.
- LD = 0, E = 1, Q == 0: Q ← MAX. WRAP ← 1.
- LD = 0, E = 0: Q holds. WRAP ← 0.
- WRAP is high for exactly one cycle after each wrap edge. Consecutive wraps (MAX = 0 with E held) keep WRAP high continuously.
- TC is combinational, with zero latency. It lets a downstream stage decrement on the same edge that this stage wraps.
- Q_n is always exactly ~Q. There is no separate register for it.
- Arithmetic is modulo 2^WIDTH, but Q never exceeds MAX: load clamps it and wrap reloads MAX. Out-of-range D is clamped, never truncated.
- State machine: RUN and, with the feature enabled, HOLD. Without the feature, the state is permanently RUN.

Optional Feature:
- Macro: DOWN_COUNTER_ONESHOT_EN.
- Defined: adds input OS (1 bit) and output DONE (1 bit).
  - In RUN with OS = 1, an E edge at Q == 0 does not wrap. Q stays 0, WRAP stays 0 and the state moves to HOLD.
  - In HOLD: DONE = 1, E is ignored, Q = 0 and TC = 0.
  - HOLD exits only on LD (→ RUN, Q ← min(D, MAX)) or on CLR.
  - OS = 0 behaves exactly as the base block.
  - DONE resets to 0.
- Undefined: the OS and DONE ports do not exist, and the counter always wraps.

Test Plan:
- Reset then count: pulse CLR, then E = 1 for 17 edges (WIDTH 4, MAX 15) → Q = 0, 15, 14, …, 1, 0, 15. WRAP is high only in the cycle after each 0 → 15 step.
- Async clear mid-count: Q = 9, assert CLR between edges → Q = 0 before the next edge. Edges during CLR are ignored.
- Load priority and clamp: MAX = 10. LD = 1, E = 1, D = 13 → Q = 10. Then LD = 1, D = 3 → Q = 3, with no decrement on either edge.
- Cascade: two instances, TC of the low stage drives E of the high stage, start at 0x00, E = 1 → sequence 0x00, 0xFF, 0xFE, …; the high stage decrements exactly on the low stage's 0 → 15 edges.
- Hold and Q_n: E = 0 for 5 edges at Q = 6 → Q = 6, Q_n = 9, TC = 0, WRAP = 0 throughout.
- One-shot (macro defined): OS = 1, load 2, E = 1 → Q = 1, 0, 0, 0; DONE = 1 from the third edge onward; WRAP never pulses. LD with D = 5 → Q = 5, DONE = 0.
